ex_operand_stage: RTL and testbench

//  ID/EX pipeline stage that directly feeds the ALU. It registers the decoded instruction, resolves
//  RAW hazards by forwarding from MEM/WB, and drives the ALU's BusA, BusB and ALUCtrl. It also

---
 rtl/ex_operand_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//   ID/EX pipeline stage feeding the ALU. Registers one decoded instruction,
//   resolves RAW hazards by forwarding from MEM and WB, and drives BusA, BusB
//   and ALUCtrl. It interlocks for one cycle on load-use, handshakes with ID
//   (valid/ready) and EX (ready), and supports a flush.
//
// Optional feature: define EX_STAGE_STATS_EN to add the StallCnt and
// BubbleCnt counter outputs. When it is undefined, those ports and counters
// are absent.
//
// Ports
//   Clk, Reset_L                  clock (rising edge), async active-low reset
//   ID_Valid / ID_Ready           capture handshake with ID
//   ID_RegA/B, ID_Imm, ID_Shamt   operand sources from decode
//   ID_ALUCtrl, ID_ALUSrcB, ID_ShiftImm, ID_Rs/Rt/Rd,
//   ID_RegWrite/MemRead/MemWrite  decoded control
//   MEM_* / WB_*                  forwarding sources
//   EX_Ready                      EX consumes when EX_Valid
//   Flush                         kill held and incoming instruction
//   EX_Valid, BusA, BusB, ALUCtrl, EX_StoreData, EX_Rd,
//   EX_RegWrite/MemRead/MemWrite  ALU-facing outputs
//   StallCnt, BubbleCnt           (EX_STAGE_STATS_EN only) statistics
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int CTRLW   = 4
) (
  input  logic               Clk,
  input  logic               Reset_L,
  input  logic               ID_Valid,
  output logic               ID_Ready,
  input  logic [WIDTH-1:0]   ID_RegA,
  input  logic [WIDTH-1:0]   ID_RegB,
  input  logic [WIDTH-1:0]   ID_Imm,
  input  logic [4:0]         ID_Shamt,
  input  logic [CTRLW-1:0]   ID_ALUCtrl,
  input  logic               ID_ALUSrcB,
  input  logic               ID_ShiftImm,
  input  logic [REGBITS-1:0] ID_Rs,
  input  logic [REGBITS-1:0] ID_Rt,
  input  logic [REGBITS-1:0] ID_Rd,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               MEM_RegWrite,
  input  logic               MEM_MemRead,
  input  logic [REGBITS-1:0] MEM_Rd,
  input  logic [WIDTH-1:0]   MEM_Result,
  input  logic               WB_RegWrite,
  input  logic [REGBITS-1:0] WB_Rd,
  input  logic [WIDTH-1:0]   WB_Result,
  input  logic               EX_Ready,
  input  logic               Flush,
  output logic               EX_Valid,
  output logic [WIDTH-1:0]   BusA,
  output logic [WIDTH-1:0]   BusB,
  output logic [CTRLW-1:0]   ALUCtrl,
  output logic [WIDTH-1:0]   EX_StoreData,
  output logic [REGBITS-1:0] EX_Rd,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite
`ifdef EX_STAGE_STATS_EN
  ,
  output logic [31:0]        StallCnt,
  output logic [31:0]        BubbleCnt
`endif
);

  localparam logic [CTRLW-1:0] C_SLL = CTRLW'(4'b0011);
  localparam logic [CTRLW-1:0] C_SRL = CTRLW'(4'b0100);
  localparam logic [CTRLW-1:0] C_SRA = CTRLW'(4'b1101);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_FULL      = 2'd1,
    S_INTERLOCK = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_rega;
  logic [WIDTH-1:0]     r_regb;
  logic [WIDTH-1:0]     r_imm;
  logic [4:0]           r_shamt;
  logic [CTRLW-1:0]     r_ctrl;
  logic                 r_alusrcb;
  logic                 r_shiftimm;
  logic [REGBITS-1:0]   r_rs;
  logic [REGBITS-1:0]   r_rt;
  logic [REGBITS-1:0]   r_rd;
  logic                 r_regwrite;
  logic                 r_memread;
  logic                 r_memwrite;

  logic                 w_fire;
  logic                 w_capture;
  logic                 w_hold;
  logic                 w_use_a_in;
  logic                 w_use_b_in;
  logic                 w_loaduse_in;
  logic [WIDTH-1:0]     w_fwd_a;
  logic [WIDTH-1:0]     w_fwd_b;
  logic [WIDTH-1:0]     w_patch_a;
  logic [WIDTH-1:0]     w_patch_b;

  function automatic logic is_shift(input logic [CTRLW-1:0] c);
    return (c == C_SLL) || (c == C_SRL) || (c == C_SRA);
  endfunction

  // Operand resolution: r0 is hard zero, then MEM (never a load, whose data
  // is not ready yet), then WB, then the stored/regfile value.
  function automatic logic [WIDTH-1:0] fwd_val(
    input logic [REGBITS-1:0] src,
    input logic [WIDTH-1:0]   stored,
    input logic               mem_rw,
    input logic               mem_mr,
    input logic [REGBITS-1:0] mem_rd,
    input logic [WIDTH-1:0]   mem_res,
    input logic               wb_rw,
    input logic [REGBITS-1:0] wb_rd,
    input logic [WIDTH-1:0]   wb_res
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if (src == '0)
      v = '0;
    else if (mem_rw && !mem_mr && (mem_rd == src))
      v = mem_res;
    else if (wb_rw && (wb_rd == src))
      v = wb_res;
    return v;
  endfunction

  // Handshake
  assign EX_Valid  = (r_state == S_FULL);
  assign w_fire    = EX_Valid & EX_Ready;
  assign ID_Ready  = Reset_L & ((r_state == S_EMPTY) | w_fire);
  assign w_capture = ID_Valid & ID_Ready;
  assign w_hold    = (r_state != S_EMPTY) & ~w_fire;

  // Source usage and load-use detection for the incoming instruction
  assign w_use_a_in   = ~(is_shift(ID_ALUCtrl) & ID_ShiftImm);
  assign w_use_b_in   = ~ID_ALUSrcB | ID_MemWrite;
  assign w_loaduse_in = MEM_MemRead & MEM_RegWrite & (MEM_Rd != '0) &
                        ((w_use_a_in & (MEM_Rd == ID_Rs)) |
                         (w_use_b_in & (MEM_Rd == ID_Rt)));

  // Held operands, resolved against the current MEM/WB contents
  assign w_fwd_a = fwd_val(r_rs, r_rega, MEM_RegWrite, MEM_MemRead, MEM_Rd,
                           MEM_Result, WB_RegWrite, WB_Rd, WB_Result);
  assign w_fwd_b = fwd_val(r_rt, r_regb, MEM_RegWrite, MEM_MemRead, MEM_Rd,
                           MEM_Result, WB_RegWrite, WB_Rd, WB_Result);

  // Incoming operands: the WB write lands in the regfile at this same edge,
  // so the regfile read data may be stale and is patched from WB.
  assign w_patch_a = fwd_val(ID_Rs, ID_RegA, 1'b0, 1'b0, '0, '0,
                             WB_RegWrite, WB_Rd, WB_Result);
  assign w_patch_b = fwd_val(ID_Rt, ID_RegB, 1'b0, 1'b0, '0, '0,
                             WB_RegWrite, WB_Rd, WB_Result);

  // Stage register and control FSM
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state    <= S_EMPTY;
      r_rega     <= '0;
      r_regb     <= '0;
      r_imm      <= '0;
      r_shamt    <= '0;
      r_ctrl     <= '0;
      r_alusrcb  <= 1'b0;
      r_shiftimm <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (Flush) begin
      r_state    <= S_EMPTY;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (w_capture) begin
      r_state    <= w_loaduse_in ? S_INTERLOCK : S_FULL;
      r_rega     <= w_patch_a;
      r_regb     <= w_patch_b;
      r_imm      <= ID_Imm;
      r_shamt    <= ID_Shamt;
      r_ctrl     <= ID_ALUCtrl;
      r_alusrcb  <= ID_ALUSrcB;
      r_shiftimm <= ID_ShiftImm;
      r_rs       <= ID_Rs;
      r_rt       <= ID_Rt;
      r_rd       <= ID_Rd;
      r_regwrite <= ID_RegWrite;
      r_memread  <= ID_MemRead;
      r_memwrite <= ID_MemWrite;
    end else if (w_fire) begin
      // Drained with nothing behind it: leave no live control bits.
      r_state    <= S_EMPTY;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (w_hold) begin
      // Refresh so a forwarded value survives its source retiring.
      r_rega <= w_fwd_a;
      r_regb <= w_fwd_b;
      if (r_state == S_INTERLOCK)
        r_state <= S_FULL;
    end
  end

  // ALU operand selection
  always_comb begin
    BusA = w_fwd_a;
    if (is_shift(r_ctrl)) begin
      if (r_shiftimm)
        BusA = {{(WIDTH-5){1'b0}}, r_shamt};
      else
        BusA = {{(WIDTH-5){1'b0}}, w_fwd_a[4:0]};
    end
  end

  // LUI arrives as the raw zero-extended 16 bits; the ALU does the shift.
  assign BusB         = r_alusrcb ? r_imm : w_fwd_b;
  assign ALUCtrl      = r_ctrl;
  assign EX_StoreData = w_fwd_b;
  assign EX_Rd        = r_rd;
  assign EX_RegWrite  = r_regwrite;
  assign EX_MemRead   = r_memread;
  assign EX_MemWrite  = r_memwrite;

`ifdef EX_STAGE_STATS_EN
  // Statistics counters (free-running, wrap at 2^32)
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (EX_Valid && !EX_Ready)
        StallCnt <= StallCnt + 32'd1;
      if (r_state == S_INTERLOCK)
        BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset_L = 1'b0;
  logic        ID_Valid = 1'b0;
  logic        ID_Ready;
  logic [31:0] ID_RegA = '0, ID_RegB = '0, ID_Imm = '0;
  logic [4:0]  ID_Shamt = '0;
  logic [3:0]  ID_ALUCtrl = '0;
  logic        ID_ALUSrcB = 1'b0, ID_ShiftImm = 1'b0;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
  logic        MEM_RegWrite = 1'b0, MEM_MemRead = 1'b0;
  logic [4:0]  MEM_Rd = '0;
  logic [31:0] MEM_Result = '0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_Rd = '0;
  logic [31:0] WB_Result = '0;
  logic        EX_Ready = 1'b0, Flush = 1'b0;
  logic        EX_Valid;
  logic [31:0] BusA, BusB, EX_StoreData;
  logic [3:0]  ALUCtrl;
  logic [4:0]  EX_Rd;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;
`ifdef EX_STAGE_STATS_EN
  logic [31:0] StallCnt, BubbleCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ex_operand_stage dut (
    .Clk(Clk), .Reset_L(Reset_L), .ID_Valid(ID_Valid), .ID_Ready(ID_Ready),
    .ID_RegA(ID_RegA), .ID_RegB(ID_RegB), .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_ALUCtrl(ID_ALUCtrl), .ID_ALUSrcB(ID_ALUSrcB), .ID_ShiftImm(ID_ShiftImm),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .MEM_Result(MEM_Result), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .WB_Result(WB_Result), .EX_Ready(EX_Ready), .Flush(Flush),
    .EX_Valid(EX_Valid), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
    .EX_StoreData(EX_StoreData), .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite)
`ifdef EX_STAGE_STATS_EN
    , .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Architectural view of a register read as seen by an instruction in EX:
  // r0 is zero; the newest producer wins; a load still in MEM has no data yet.
  function automatic logic [31:0] model_read(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return 32'd0;
    if (MEM_RegWrite && !MEM_MemRead && MEM_Rd == src) return MEM_Result;
    if (WB_RegWrite && WB_Rd == src) return WB_Result;
    return rf;
  endfunction

  function automatic bit model_is_shift(input logic [3:0] c);
    return c == 4'b0011 || c == 4'b0100 || c == 4'b1101;
  endfunction

  task automatic set_instr(input logic [3:0] ctrl, input logic [4:0] rs, input logic [31:0] ra,
                           input logic [4:0] rt, input logic [31:0] rb, input logic srcb,
                           input logic [31:0] imm, input logic shimm, input logic [4:0] shamt);
    ID_ALUCtrl = ctrl; ID_Rs = rs; ID_RegA = ra; ID_Rt = rt; ID_RegB = rb;
    ID_ALUSrcB = srcb; ID_Imm = imm; ID_ShiftImm = shimm; ID_Shamt = shamt;
    ID_Rd = 5'd9; ID_RegWrite = 1'b1; ID_MemRead = 1'b0; ID_MemWrite = 1'b0;
  endtask

  task automatic clear_fwd();
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_Rd = 0; MEM_Result = 0;
    WB_RegWrite = 0; WB_Rd = 0; WB_Result = 0;
  endtask

  // One instruction through the stage with MEM/WB stable for its whole stay.
  task automatic run_instr(input string tag, input int hold);
    logic [31:0] ea, eb, exp_a, exp_b;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw, sh, use_a, use_b, hz;
    sh    = model_is_shift(ID_ALUCtrl);
    use_a = !(sh && ID_ShiftImm);
    use_b = !ID_ALUSrcB || ID_MemWrite;
    hz    = MEM_RegWrite && MEM_MemRead && MEM_Rd != 0 &&
            ((use_a && MEM_Rd == ID_Rs) || (use_b && MEM_Rd == ID_Rt));
    ea    = model_read(ID_Rs, ID_RegA);
    eb    = model_read(ID_Rt, ID_RegB);
    exp_a = sh ? (ID_ShiftImm ? {27'd0, ID_Shamt} : (ea & 32'h1f)) : ea;
    exp_b = ID_ALUSrcB ? ID_Imm : eb;
    e_ctrl = ID_ALUCtrl; e_rd = ID_Rd;
    e_rw = ID_RegWrite; e_mr = ID_MemRead; e_mw = ID_MemWrite;
    ID_Valid = 1; EX_Ready = 0;
    #1;
    chk({tag, ".id_ready"}, 32'(ID_Ready), 32'd1);
    tick();
    ID_Valid = 0;
    ID_RegA = $urandom; ID_RegB = $urandom; ID_Imm = $urandom; ID_Rd = 5'(~e_rd);
    #1;
    if (hz) begin
      chk({tag, ".bubble"}, 32'(EX_Valid), 32'd0);
      chk({tag, ".bubble_rdy"}, 32'(ID_Ready), 32'd0);
      tick();
    end
    chk({tag, ".valid"}, 32'(EX_Valid), 32'd1);
    chk({tag, ".busa"}, BusA, exp_a);
    chk({tag, ".busb"}, BusB, exp_b);
    chk({tag, ".store"}, EX_StoreData, eb);
    chk({tag, ".ctrl"}, 32'(ALUCtrl), 32'(e_ctrl));
    chk({tag, ".rd"}, 32'(EX_Rd), 32'(e_rd));
    chk({tag, ".cbits"}, {29'd0, EX_RegWrite, EX_MemRead, EX_MemWrite}, {29'd0, e_rw, e_mr, e_mw});
    for (int i = 0; i < hold; i++) tick();
    chk({tag, ".busa_held"}, BusA, exp_a);
    EX_Ready = 1;
    #1;
    chk({tag, ".fire_rdy"}, 32'(ID_Ready), 32'd1);
    tick();
    EX_Ready = 0;
    chk({tag, ".drained"}, 32'(EX_Valid), 32'd0);
  endtask

  function automatic logic [4:0] pick_rd(input logic [4:0] rs, input logic [4:0] rt);
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return rs;
      2: return rt;
      default: return 5'($urandom_range(0, 7));
    endcase
  endfunction

  logic [3:0] codes [14] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};

  initial begin
    // Reset state
    #2;
    chk("rst.valid", 32'(EX_Valid), 32'd0);
    chk("rst.id_ready", 32'(ID_Ready), 32'd0);
    chk("rst.busa", BusA, 32'd0);
    chk("rst.regwrite", 32'(EX_RegWrite), 32'd0);
    tick(); tick();
    Reset_L = 1;
    #1;
    chk("post_rst.id_ready", 32'(ID_Ready), 32'd1);

    // ADD, no hazards
    clear_fwd();
    set_instr(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    run_instr("add", 0);

    // MEM beats WB; r0 never forwards
    MEM_RegWrite = 1; MEM_Rd = 5'd1; MEM_Result = 32'h10;
    WB_RegWrite = 1; WB_Rd = 5'd1; WB_Result = 32'h20;
    set_instr(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    run_instr("fwd_prio", 1);
    MEM_Rd = 5'd0; MEM_Result = 32'hFFFF;
    set_instr(4'b0010, 5'd0, 32'h55, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    run_instr("r0", 0);
    clear_fwd();

    // Shifts and LUI
    set_instr(4'b0011, 5'd6, 32'h99, 5'd2, 32'd7, 0, 32'd0, 1, 5'd4);
    run_instr("sll", 0);
    set_instr(4'b0011, 5'd6, 32'hFFFFFF23, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    run_instr("sllv", 0);
    set_instr(4'b1110, 5'd0, 32'd0, 5'd2, 32'd7, 1, 32'h1234, 0, 5'd0);
    run_instr("lui", 0);

    // Load-use: load moves MEM -> WB during the bubble, then retires
    set_instr(4'b0010, 5'd3, 32'hDEAD, 5'd4, 32'd1, 0, 32'd0, 0, 5'd0);
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_Rd = 5'd3; MEM_Result = 32'hBAD;
    ID_Valid = 1;
    tick();
    ID_Valid = 0;
    clear_fwd();
    WB_RegWrite = 1; WB_Rd = 5'd3; WB_Result = 32'h12345678;
    #1;
    chk("lu.bubble", 32'(EX_Valid), 32'd0);
    chk("lu.id_ready", 32'(ID_Ready), 32'd0);
    tick();
    clear_fwd();
    #1;
    chk("lu.valid", 32'(EX_Valid), 32'd1);
    chk("lu.busa", BusA, 32'h12345678);
    EX_Ready = 1;
    tick();
    EX_Ready = 0;

    // WB-forwarded value survives WB retiring while stalled; then flush
    set_instr(4'b0010, 5'd5, 32'h111, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    WB_RegWrite = 1; WB_Rd = 5'd5; WB_Result = 32'hABCD;
    ID_Valid = 1;
    tick();
    ID_Valid = 0;
    WB_Rd = 5'd9; WB_Result = 32'd0;
    #1;
    chk("stall.busa0", BusA, 32'hABCD);
    for (int i = 0; i < 3; i++) tick();
    chk("stall.busa3", BusA, 32'hABCD);
    chk("stall.valid", 32'(EX_Valid), 32'd1);
    clear_fwd();
    set_instr(4'b0001, 5'd7, 32'h77, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    ID_Valid = 1; Flush = 1;
    tick();
    ID_Valid = 0; Flush = 0;
    chk("flush.valid", 32'(EX_Valid), 32'd0);
    chk("flush.regwrite", 32'(EX_RegWrite), 32'd0);
    tick();
    chk("flush.nocapture", 32'(EX_Valid), 32'd0);

    // Back-to-back capture concurrent with fire
    set_instr(4'b0010, 5'd1, 32'hA1, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    ID_Valid = 1;
    tick();
    set_instr(4'b1010, 5'd3, 32'hB2, 5'd4, 32'd8, 0, 32'd0, 0, 5'd0);
    EX_Ready = 1;
    #1;
    chk("b2b.ready", 32'(ID_Ready), 32'd1);
    tick();
    ID_Valid = 0;
    chk("b2b.valid", 32'(EX_Valid), 32'd1);
    chk("b2b.busa", BusA, 32'hB2);
    chk("b2b.ctrl", 32'(ALUCtrl), 32'b1010);
    tick();
    EX_Ready = 0;
    chk("b2b.drain", 32'(EX_Valid), 32'd0);

    // Reset mid-operation
    set_instr(4'b0010, 5'd1, 32'hCC, 5'd2, 32'd7, 0, 32'd0, 0, 5'd0);
    ID_Valid = 1;
    tick();
    ID_Valid = 0;
    Reset_L = 0;
    #1;
    chk("midrst.valid", 32'(EX_Valid), 32'd0);
    chk("midrst.busa", BusA, 32'd0);
    chk("midrst.id_ready", 32'(ID_Ready), 32'd0);
    #2;
    Reset_L = 1;
    tick();

`ifdef EX_STAGE_STATS_EN
    chk("stats.rst_stall", StallCnt, 32'd0);
    set_instr(4'b0010, 5'd3, 32'h1, 5'd4, 32'd1, 0, 32'd0, 0, 5'd0);
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_Rd = 5'd3;
    ID_Valid = 1;
    tick();
    ID_Valid = 0;
    clear_fwd();
    tick();
    for (int i = 0; i < 3; i++) tick();
    EX_Ready = 1;
    tick();
    EX_Ready = 0;
    chk("stats.stall", StallCnt, 32'd3);
    chk("stats.bubble", BubbleCnt, 32'd1);
    Reset_L = 0;
    #1;
    chk("stats.clr_stall", StallCnt, 32'd0);
    chk("stats.clr_bubble", BubbleCnt, 32'd0);
    #2;
    Reset_L = 1;
    tick();
`endif

    // Randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rs, rt;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      set_instr(codes[$urandom_range(0, 13)], rs, $urandom, rt, $urandom,
                1'($urandom), $urandom, 1'($urandom), 5'($urandom));
      ID_Rd = 5'($urandom); ID_RegWrite = 1'($urandom);
      ID_MemRead = 1'($urandom); ID_MemWrite = ($urandom_range(0, 3) == 0);
      MEM_RegWrite = 1'($urandom); MEM_MemRead = ($urandom_range(0, 2) == 0);
      MEM_Rd = pick_rd(rs, rt); MEM_Result = $urandom;
      WB_RegWrite = 1'($urandom); WB_Rd = pick_rd(rs, rt); WB_Result = $urandom;
      run_instr("rand", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
